// File: rtl/bank_fetch_arbiter.sv
// Round-robin arbiter sharing the two-bank parity memory between two requesters.
// Optional build macro PARITY_RETRY_EN: re-read once on a parity mismatch before reporting it.
module bank_fetch_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_parity,
    output logic              rvalid,
    output logic              rid,
    output logic [DATA_W-1:0] rdata,
    output logic              perr,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        CHECK  = 2'd2
    } state_t;

    // Memory stores even parity: the parity bit equals the XOR of the data bits.
    function automatic logic parity_mismatch(input logic [DATA_W-1:0] d, input logic p);
        return (^d) != p;
    endfunction

    state_t            state_r, state_s;
    logic              gnt0_r, gnt0_s;
    logic              gnt1_r, gnt1_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic              rvalid_r, rvalid_s;
    logic              rid_r, rid_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    logic              perr_r, perr_s;
    logic              busy_r, busy_s;
    logic              last_r, last_s;
    logic              rid_q_r, rid_q_s;
    logic [DATA_W-1:0] cap_data_r, cap_data_s;
    logic              cap_par_r, cap_par_s;
    logic              win_s;
    logic              mismatch_s;
    logic              respond_s;
`ifdef PARITY_RETRY_EN
    logic              retry_r, retry_s;
`endif

    // Next-state and next-output computation for every register.
    always_comb begin
        state_s    = state_r;
        gnt0_s     = 1'b0;
        gnt1_s     = 1'b0;
        mem_addr_s = mem_addr_r;
        rvalid_s   = 1'b0;
        rid_s      = rid_r;
        rdata_s    = rdata_r;
        perr_s     = 1'b0;
        last_s     = last_r;
        rid_q_s    = rid_q_r;
        cap_data_s = cap_data_r;
        cap_par_s  = cap_par_r;
        respond_s  = 1'b0;
`ifdef PARITY_RETRY_EN
        retry_s    = retry_r;
`endif
        mismatch_s = parity_mismatch(cap_data_r, cap_par_r);

        // On a tie the requester that was not served last wins.
        if (req0 && req1) begin
            win_s = ~last_r;
        end else if (req0) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end

        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    state_s    = LOOKUP;
                    rid_q_s    = win_s;
                    mem_addr_s = win_s ? addr1 : addr0;
                    gnt0_s     = ~win_s;
                    gnt1_s     = win_s;
`ifdef PARITY_RETRY_EN
                    retry_s    = 1'b0;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            LOOKUP: begin
                cap_data_s = mem_data;
                cap_par_s  = mem_parity;
                state_s    = CHECK;
            end
            CHECK: begin
`ifdef PARITY_RETRY_EN
                if (mismatch_s && !retry_r) begin
                    retry_s = 1'b1;
                    state_s = LOOKUP;
                end else begin
                    respond_s = 1'b1;
                end
`else
                respond_s = 1'b1;
`endif
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (respond_s) begin
            rvalid_s = 1'b1;
            rdata_s  = cap_data_r;
            rid_s    = rid_q_r;
            perr_s   = mismatch_s;
            last_s   = rid_q_r;
            state_s  = IDLE;
        end else begin
            rvalid_s = 1'b0;
        end

        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            rvalid_r   <= 1'b0;
            rid_r      <= 1'b0;
            rdata_r    <= {DATA_W{1'b0}};
            perr_r     <= 1'b0;
            busy_r     <= 1'b0;
            last_r     <= 1'b1;
            rid_q_r    <= 1'b0;
            cap_data_r <= {DATA_W{1'b0}};
            cap_par_r  <= 1'b0;
`ifdef PARITY_RETRY_EN
            retry_r    <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            gnt0_r     <= gnt0_s;
            gnt1_r     <= gnt1_s;
            mem_addr_r <= mem_addr_s;
            rvalid_r   <= rvalid_s;
            rid_r      <= rid_s;
            rdata_r    <= rdata_s;
            perr_r     <= perr_s;
            busy_r     <= busy_s;
            last_r     <= last_s;
            rid_q_r    <= rid_q_s;
            cap_data_r <= cap_data_s;
            cap_par_r  <= cap_par_s;
`ifdef PARITY_RETRY_EN
            retry_r    <= retry_s;
`endif
        end
    end

    assign gnt0     = gnt0_r;
    assign gnt1     = gnt1_r;
    assign mem_addr = mem_addr_r;
    assign rvalid   = rvalid_r;
    assign rid      = rid_r;
    assign rdata    = rdata_r;
    assign perr     = perr_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_bank_fetch_arbiter.sv
// Directed self-checking bench for bank_fetch_arbiter with a stub parity memory.
module tb_bank_fetch_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [3:0] addr0, addr1;
    logic       gnt0, gnt1;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_parity;
    logic       rvalid, rid, perr, busy;
    logic [7:0] rdata;

    logic [7:0] mem_tab [16];
    logic       flip;
    int         checks = 0;
    int         errors = 0;

    bank_fetch_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_parity(mem_parity),
        .rvalid(rvalid), .rid(rid), .rdata(rdata), .perr(perr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stub memory: even parity, optionally corrupted by flip.
    always_comb begin
        mem_data   = mem_tab[mem_addr];
        mem_parity = (^mem_tab[mem_addr]) ^ flip;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b%b want 00", gnt0, gnt1); end
        checks++; if (rvalid !== 1'b0 || perr !== 1'b0) begin errors++; $display("FAIL reset_strobes got rvalid=%b perr=%b want 0 0", rvalid, perr); end
        checks++; if (rid !== 1'b0 || rdata !== 8'h00) begin errors++; $display("FAIL reset_resp got rid=%b rdata=%h want 0 00", rid, rdata); end
        checks++; if (mem_addr !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL reset_addr_busy got %h %b want 0 0", mem_addr, busy); end
        reset = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || gnt0 !== 1'b0) begin errors++; $display("FAIL idle_after_reset got busy=%b gnt0=%b want 0 0", busy, gnt0); end
    endtask

    task automatic test_access(input logic who, input logic [3:0] a, input logic [7:0] d, input logic pe);
        if (who) begin req1 = 1'b1; addr1 = a; end
        else begin req0 = 1'b1; addr0 = a; end
        step();
        checks++; if (gnt0 !== ~who || gnt1 !== who) begin errors++; $display("FAIL access_gnt got %b%b want %b%b", gnt1, gnt0, who, ~who); end
        checks++; if (mem_addr !== a || busy !== 1'b1) begin errors++; $display("FAIL access_addr got %h busy=%b want %h 1", mem_addr, busy, a); end
        req0 = 1'b0; req1 = 1'b0;
        step();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || rvalid !== 1'b0) begin errors++; $display("FAIL access_lookup got gnt=%b%b rvalid=%b want 00 0", gnt1, gnt0, rvalid); end
        step();
        checks++; if (rvalid !== 1'b1 || rid !== who || rdata !== d || perr !== pe) begin errors++; $display("FAIL access_resp got v=%b rid=%b data=%h perr=%b want 1 %b %h %b", rvalid, rid, rdata, perr, who, d, pe); end
        step();
        checks++; if (rvalid !== 1'b0 || perr !== 1'b0 || busy !== 1'b0 || rdata !== d || rid !== who) begin errors++; $display("FAIL access_after got v=%b perr=%b busy=%b data=%h rid=%b want 0 0 0 %h %b", rvalid, perr, busy, rdata, rid, d, who); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d;
        logic       exp_w;
        reset = 1'b1;
        req0 = 1'b1; addr0 = 4'h7;
        req1 = 1'b1; addr1 = 4'h9;
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_w = (k % 2 == 1);
            exp_d = exp_w ? 8'h22 : 8'hFD;
            step();
            checks++; if (gnt0 !== ~exp_w || gnt1 !== exp_w) begin errors++; $display("FAIL rr_gnt%0d got %b%b want %b%b", k, gnt1, gnt0, exp_w, ~exp_w); end
            step();
            step();
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
            checks++; if (rvalid !== 1'b1 || rid !== exp_w || rdata !== exp_d) begin errors++; $display("FAIL rr_resp%0d got v=%b rid=%b data=%h want 1 %b %h", k, rvalid, rid, rdata, exp_w, exp_d); end
        end
        step();
    endtask

    task automatic test_reset_mid();
        test_access(1'b0, 4'h1, 8'h31, 1'b0);
        req0 = 1'b1; addr0 = 4'h1;
        req1 = 1'b1; addr1 = 4'hF;
        step();
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL mid_fair_gnt got %b%b want 10", gnt1, gnt0); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0 || rvalid !== 1'b0 || mem_addr !== 4'h0) begin errors++; $display("FAIL mid_reset got gnt=%b%b busy=%b v=%b addr=%h want 00 0 0 0", gnt1, gnt0, busy, rvalid, mem_addr); end
        step();
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL mid_tie_after_reset got %b%b want 01", gnt1, gnt0); end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        checks++; if (rvalid !== 1'b1 || rid !== 1'b0 || rdata !== 8'h31) begin errors++; $display("FAIL mid_resp got v=%b rid=%b data=%h want 1 0 31", rvalid, rid, rdata); end
        step();
    endtask

    task automatic test_withdraw();
        int n_g0, n_v;
        n_g0 = 0; n_v = 0;
        req1 = 1'b1; addr1 = 4'hF;
        step();
        checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL wd_gnt1 got %b want 1", gnt1); end
        req1 = 1'b0;
        req0 = 1'b1; addr0 = 4'h7;
        step();
        req0 = 1'b0;
        step();
        checks++; if (rvalid !== 1'b1 || rid !== 1'b1 || rdata !== 8'hEE) begin errors++; $display("FAIL wd_resp got v=%b rid=%b data=%h want 1 1 ee", rvalid, rid, rdata); end
        for (int c = 0; c < 5; c++) begin
            step();
            if (gnt0 === 1'b1) n_g0++;
            if (rvalid === 1'b1) n_v++;
        end
        checks++; if (n_g0 !== 0 || n_v !== 0 || busy !== 1'b0) begin errors++; $display("FAIL wd_no_side_effect got gnt0s=%0d rvalids=%0d busy=%b want 0 0 0", n_g0, n_v, busy); end
    endtask

    task automatic test_parity(input logic fix_second);
        flip = 1'b1;
        req0 = 1'b1; addr0 = 4'h1;
        step();
        req0 = 1'b0;
        step();
`ifdef PARITY_RETRY_EN
        step();
        checks++; if (rvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL par_retry_hold got v=%b busy=%b want 0 1", rvalid, busy); end
        if (fix_second) flip = 1'b0;
        step();
        step();
        checks++; if (rvalid !== 1'b1 || rdata !== 8'h31 || perr !== ~fix_second) begin errors++; $display("FAIL par_retry_resp got v=%b data=%h perr=%b want 1 31 %b", rvalid, rdata, perr, ~fix_second); end
`else
        step();
        checks++; if (rvalid !== 1'b1 || rdata !== 8'h31 || perr !== 1'b1) begin errors++; $display("FAIL par_resp got v=%b data=%h perr=%b want 1 31 1 (fix=%b)", rvalid, rdata, perr, fix_second); end
`endif
        flip = 1'b0;
        step();
        checks++; if (rvalid !== 1'b0 || perr !== 1'b0) begin errors++; $display("FAIL par_strobe_end got v=%b perr=%b want 0 0", rvalid, perr); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_tab[i] = 8'h40 + 8'(i);
        mem_tab[1]  = 8'h31;
        mem_tab[7]  = 8'hFD;
        mem_tab[9]  = 8'h22;
        mem_tab[15] = 8'hEE;
        flip = 1'b0;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = 4'h0; addr1 = 4'h0;

        test_reset();
        test_access(1'b0, 4'h1, 8'h31, 1'b0);
        test_access(1'b1, 4'h9, 8'h22, 1'b0);
        test_access(1'b1, 4'hF, 8'hEE, 1'b0);
        test_access(1'b0, 4'h7, 8'hFD, 1'b0);
        test_round_robin();
        test_reset_mid();
        test_withdraw();
        test_parity(1'b0);
        test_parity(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
